// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch-stage program counter.
// Imported by pc_gen and by the redirect buffer.
package pc_gen_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int STALL_PC = 0;

  localparam int INST_ADDR_W    = 32;
  localparam int INST_BYTES_DEF = 4;

  typedef enum logic {
    PC_OFF = 1'b0,
    PC_RUN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// Single-entry holding register for a branch target that arrived while fetch
// could not advance. The target is stored already aligned.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              consume,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target,
  output logic              pending,
  output logic [ADDR_W-1:0] pend_tgt
);

  logic              pending_reg;
  logic              pending_next;
  logic [ADDR_W-1:0] tgt_reg;
  logic [ADDR_W-1:0] tgt_next;

  // A capture always wins over a consume so a newer target is never lost.
  always_comb begin
    pending_next = pending_reg;
    tgt_next     = tgt_reg;
    if (clear) begin
      pending_next = 1'b0;
    end else if (capture) begin
      pending_next = 1'b1;
      tgt_next     = target;
    end else if (consume) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pending_reg <= 1'b0;
      tgt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      tgt_reg     <= tgt_next;
    end
  end

  assign pending  = pending_reg;
  assign pend_tgt = tgt_reg;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential increment, branch redirect with
// buffering across stalls, exception flush and misaligned-target reporting.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = INST_BYTES_DEF,
  parameter int                STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               rom_ready_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               addr_err_o
);

  // Ones above the instruction-offset bits; works for INST_BYTES == 1 too.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  pc_state_e         state_reg;
  pc_state_e         state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              ce_reg;
  logic              ce_next;
  logic              addr_err_reg;
  logic              addr_err_next;

  logic              advance;
  logic              buf_capture;
  logic              buf_consume;
  logic              buf_clear;
  logic              pending;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] branch_aligned;
  logic [ADDR_W-1:0] flush_aligned;
  logic              branch_misalign;
  logic              flush_misalign;

  assign advance         = (state_reg == PC_RUN) & ~stall[STALL_PC] & rom_ready_i;
  assign branch_aligned  = branch_target_i & ALIGN_MASK;
  assign flush_aligned   = flush_pc & ALIGN_MASK;
  assign branch_misalign = |(branch_target_i & ~ALIGN_MASK);
  assign flush_misalign  = |(flush_pc & ~ALIGN_MASK);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ce_next       = ce_reg;
    addr_err_next = 1'b0;
    buf_capture   = 1'b0;
    buf_consume   = 1'b0;
    buf_clear     = 1'b0;
    unique case (state_reg)
      PC_OFF: begin
        state_next = PC_RUN;
        ce_next    = CHIP_ENABLE;
        pc_next    = RESET_VEC;
      end
      PC_RUN: begin
        ce_next = CHIP_ENABLE;
        if (flush) begin
          pc_next       = flush_aligned;
          buf_clear     = 1'b1;
          addr_err_next = flush_misalign;
        end else if (pending && advance) begin
          // A branch arriving alongside is dropped; ID re-presents it if still taken.
          pc_next     = pend_tgt;
          buf_consume = 1'b1;
        end else if (branch_flag_i && advance) begin
          pc_next       = branch_aligned;
          addr_err_next = branch_misalign;
        end else if (branch_flag_i) begin
          buf_capture   = 1'b1;
          addr_err_next = branch_misalign;
        end else if (advance) begin
          pc_next = pc_reg + PC_STEP;
        end
      end
      default: begin
        state_next = PC_OFF;
        ce_next    = CHIP_DISABLE;
        pc_next    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg    <= PC_OFF;
      pc_reg       <= RESET_VEC;
      ce_reg       <= CHIP_DISABLE;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ce_reg       <= ce_next;
      addr_err_reg <= addr_err_next;
    end
  end

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (buf_capture),
    .consume (buf_consume),
    .clear   (buf_clear),
    .target  (branch_aligned),
    .pending (pending),
    .pend_tgt(pend_tgt)
  );

  assign pc                 = pc_reg;
  assign ce                 = ce_reg;
  assign redirect_pending_o = pending;
  assign addr_err_o         = addr_err_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each step drives inputs, advances one clock and
// compares registered outputs against hand-computed values.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ready_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  logic        addr_err_o;

  int passed;
  int total;

  pc_gen dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .branch_flag_i     (branch_flag_i),
    .branch_target_i   (branch_target_i),
    .rom_ready_i       (rom_ready_i),
    .pc                (pc),
    .ce                (ce),
    .redirect_pending_o(redirect_pending_o),
    .addr_err_o        (addr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s observed=%08h expected=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic exp_ce,
                             input logic exp_pend, input logic exp_err);
    check({tag, ".pc"},   pc,                          exp_pc);
    check({tag, ".ce"},   {31'd0, ce},                 {31'd0, exp_ce});
    check({tag, ".pend"}, {31'd0, redirect_pending_o}, {31'd0, exp_pend});
    check({tag, ".err"},  {31'd0, addr_err_o},         {31'd0, exp_err});
  endtask

  initial begin
    passed          = 0;
    total           = 0;
    rst             = 1'b0;
    stall           = '0;
    flush           = 1'b0;
    flush_pc        = '0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    rom_ready_i     = 1'b1;

    // 1. reset and boot
    tick(); check_state("rst0", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check_state("rst1", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check_state("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); check_state("boot", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check("inc4",  pc, 32'h4);
    tick(); check("inc8",  pc, 32'h8);
    tick(); check("incC",  pc, 32'hC);
    tick(); check("inc10", pc, 32'h10);

    // 2. stall and rom back-pressure
    stall = 6'b000001;
    tick(); check("stall_a", pc, 32'h10);
    tick(); check("stall_b", pc, 32'h10);
    stall = '0; rom_ready_i = 1'b0;
    tick(); check("notready", pc, 32'h10);
    rom_ready_i = 1'b1;
    tick(); check("resume", pc, 32'h14);
    stall = 6'b111110;
    tick(); check("upperstall", pc, 32'h18);
    stall = '0;
    tick(); check("to1C", pc, 32'h1C);
    tick(); check("to20", pc, 32'h20);

    // 3. buffered branch
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick(); check_state("bufcap", 32'h20, 1'b1, 1'b1, 1'b0);
    branch_flag_i = 1'b0;
    tick(); check_state("bufhold1", 32'h20, 1'b1, 1'b1, 1'b0);
    tick(); check_state("bufhold2", 32'h20, 1'b1, 1'b1, 1'b0);
    stall = '0;
    tick(); check_state("bufapply", 32'h100, 1'b1, 1'b0, 1'b0);
    tick(); check("bufnext", pc, 32'h104);

    // 4. flush beats branch, pending and stall
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick(); check_state("prepend", 32'h104, 1'b1, 1'b1, 1'b0);
    flush = 1'b1; flush_pc = 32'h180; branch_target_i = 32'h200;
    tick(); check_state("flush", 32'h180, 1'b1, 1'b0, 1'b0);
    flush = 1'b0; branch_flag_i = 1'b0; stall = '0;
    tick(); check_state("postflush", 32'h184, 1'b1, 1'b0, 1'b0);

    // 5. misaligned targets
    branch_flag_i = 1'b1; branch_target_i = 32'h103;
    tick(); check_state("misbr", 32'h100, 1'b1, 1'b0, 1'b1);
    branch_flag_i = 1'b0;
    tick(); check_state("misclr", 32'h104, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; flush_pc = 32'h182;
    tick(); check_state("misflush", 32'h180, 1'b1, 1'b0, 1'b1);
    flush = 1'b0;
    tick(); check_state("misflush2", 32'h184, 1'b1, 1'b0, 1'b0);

    // newer buffered target overwrites older one
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick(); check("ovw_a", pc, 32'h184);
    branch_target_i = 32'h342;
    tick(); check_state("ovw_b", 32'h184, 1'b1, 1'b1, 1'b1);
    branch_flag_i = 1'b0; stall = '0;
    tick(); check_state("ovw_apply", 32'h340, 1'b1, 1'b0, 1'b0);

    // 6. wrap-around
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick(); check("towrap", pc, 32'hFFFF_FFFC);
    branch_flag_i = 1'b0;
    tick(); check("wrap0", pc, 32'h0);
    tick(); check("wrap4", pc, 32'h4);

    // mid-operation reset with a pending redirect
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h40;
    tick(); check_state("rpend", 32'h4, 1'b1, 1'b1, 1'b0);
    branch_flag_i = 1'b0; rst = 1'b0;
    tick(); check_state("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; stall = '0;
    tick(); check_state("reboot", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check_state("reboot4", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor of the fetch-stage program counter.
- Generates the instruction-fetch address and the instruction ROM chip-enable.
- Adds:
  - configurable address width, reset vector and instruction size;
  - pipeline stall input;
  - branch redirect, with buffering of a branch that arrives while the fetch is stalled;
  - exception flush;
  - ROM-ready back-pressure;
  - misaligned-target detection.
- Sits at the head of the IF stage; drives the instruction ROM and the IF/ID register.

Parameters:
- ADDR_W, 32: width of pc, branch and flush targets.
- RESET_VEC, 32'h0000_0000: first fetch address after reset (ADDR_W bits).
- INST_BYTES, 4: pc increment. Must be a power of two, ≥1.
- STALL_W, 6: width of the pipeline stall vector from ctrl. Bit 0 is the PC stall.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-low; sampled on rising edge of clk.
- stall, input, STALL_W: pipeline stall vector. Only bit 0 is used here.
- flush, input, 1: exception/eret flush request.
- flush_pc, input, ADDR_W: flush target (exception handler or EPC).
- branch_flag_i, input, 1: branch/jump taken, from ID.
- branch_target_i, input, ADDR_W: branch/jump target.
- rom_ready_i, input, 1: instruction ROM accepted the current fetch address this cycle.
- pc, output, ADDR_W: current fetch address.
- ce, output, 1: instruction ROM enable.
- redirect_pending_o, output, 1: a buffered branch target is waiting to be applied.
- addr_err_o, output, 1: one-cycle pulse; the applied target had nonzero low bits.

Behaviour:
- All state updates on the rising clk edge. No combinational path from inputs to outputs.

Reset (rst==0):
- state<=OFF, ce<=0, pc<=RESET_VEC.
- pending<=0, pend_tgt<=0, addr_err_o<=0.
- Reset overrides every other input, including mid-stall and mid-pending.

State machine (2 states):
- OFF: ce=0, pc held at RESET_VEC. When rst==1, go to RUN and set ce<=1; pc stays RESET_VEC.
- RUN: ce=1. Remains in RUN until rst==0.
- The first address presented with ce=1 is RESET_VEC. The first increment happens on the first "advance" cycle.

Definitions:
- advance = (state==RUN) & ~stall[0] & rom_ready_i.
- align(x) = x with the low log2(INST_BYTES) bits forced to 0.
- misalign(x) = those low bits are nonzero.

RUN next-state priority (highest first):
1. flush:
   - pc<=align(flush_pc); pending<=0.
   - Applied regardless of stall or rom_ready_i.
   - Any simultaneous branch_flag_i is discarded.
2. pending & advance:
   - pc<=pend_tgt (already aligned); pending<=0.
   - A simultaneous branch_flag_i is treated as case 3 on the next advance cycle only if it is still asserted then.
3. branch_flag_i & advance: pc<=align(branch_target_i).
4. branch_flag_i & ~advance:
   - pend_tgt<=align(branch_target_i); pending<=1; pc held.
   - If already pending, the newer target overwrites the older one.
5. advance: pc<=pc+INST_BYTES, truncated to ADDR_W (wraps 0xFFFF_FFFC→0x0 for 32/4).
6. Otherwise: hold pc.

Outputs:
- addr_err_o<=1 for exactly one cycle when a target that is captured or applied in cases 1, 3 or 4 has misalign==1. Otherwise it is 0.
- redirect_pending_o = pending (registered).
- Latency: redirect or flush is visible on pc one cycle after the request edge. Buffered branch latency is 1 cycle after the stall releases.

Decomposition:
- Shared defines package:
  - RST_ENABLE = 1'b0 (active-low).
  - CHIP_ENABLE / CHIP_DISABLE.
  - STALL_PC bit index = 0.
  - Default INST_ADDR width and INST_BYTES.
  - State encodings PC_OFF / PC_RUN.
- One sub-module: pc_redirect_buf.
  - Holds pending and pend_tgt.
  - Inputs: capture, consume, clear (flush), rst.
  - Reused later by a dual-issue fetch unit.

Test Plan:
1. Reset and boot:
   - Stimulus: rst=0 for 3 cycles, then 1; stall=0; rom_ready_i=1.
   - Required: ce=0 and pc=0 during reset. Cycle 1 after release: ce=1, pc=0. Then pc = 4, 8, 12 on successive cycles.
2. Stall and back-pressure:
   - Stimulus: at pc=0x10, stall[0]=1 for 2 cycles, then rom_ready_i=0 for 1 cycle.
   - Required: pc stays 0x10 for 3 cycles, then 0x14.
3. Buffered branch:
   - Stimulus: stall[0]=1 at pc=0x20; branch_flag_i=1 with target 0x100 for one cycle; stall held 2 more cycles.
   - Required: redirect_pending_o=1 and pc=0x20 during the stall. First cycle after the stall releases: pc=0x100, pending=0. Next cycle: pc=0x104.
4. Flush priority:
   - Stimulus: flush=1 with flush_pc=0x180, branch_flag_i=1 with target 0x200, pending set, stall[0]=1, all in the same cycle.
   - Required: pc=0x180 next cycle, pending=0. The 0x200 target is never applied.
5. Misaligned target:
   - Stimulus: branch_flag_i=1 with target 0x103 while advancing.
   - Required: pc=0x100 and addr_err_o=1 for one cycle.
6. Wrap-around and mid-operation reset:
   - Wrap stimulus: pc=0xFFFF_FFFC, advance. Required: pc=0x0.
   - Reset stimulus: rst=0 while pending=1. Required: pending=0, ce=0, pc=RESET_VEC next cycle.
